// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-copy DMA.
// State encoding, word size and default read-wait length.
`timescale 1ns/1ps
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] WORD_BYTES    = 32'd4;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam int unsigned READ_WAIT_DEF = 4;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_copy_wait_cnt.sv
// Down-counter timing the read strobe hold window.
// Loaded on entry to a read; last is high in its final cycle.
`timescale 1ns/1ps
module mem_copy_wait_cnt #(
  parameter int unsigned READ_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam logic [3:0] LOAD_VAL = 4'(READ_WAIT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign last = en && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_copy_dma.sv
// Forward word-copy engine for an async, fixed-latency memory.
// Each word is one timed read followed by a single write cycle.
`timescale 1ns/1ps
module mem_copy_dma
  import mem_copy_pkg::*;
#(
  parameter int unsigned READ_WAIT = READ_WAIT_DEF,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             wt_load;
  logic             wt_last;

  mem_copy_wait_cnt #(
    .READ_WAIT(READ_WAIT)
  ) u_wait (
    .clk  (clk),
    .rst_n(reset),
    .load (wt_load),
    .en   (state_q == RD),
    .last (wt_last)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wt_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && word_count != '0) begin
          src_d   = word_align(src_addr);
          dst_d   = word_align(dst_addr);
          cnt_d   = word_count;
          wt_load = 1'b1;
          state_d = RD;
        end else if (start) begin
          state_d = DONE;
        end
      end
      RD: begin
        if (wt_last) begin
          data_d  = mem_read_data;
          state_d = WR;
        end
      end
      WR: begin
        src_d = src_q + WORD_BYTES;
        dst_d = dst_q + WORD_BYTES;
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q still holds this word, so 1 means it was the last
        if (cnt_q != CNT_W'(1)) begin
          wt_load = 1'b1;
          state_d = RD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_read  = (state_q == RD);
  assign mem_write = (state_q == WR);

  assign mem_addr = mem_read  ? src_q :
                    mem_write ? dst_q : 32'h0;

  assign mem_write_data = mem_write ? data_q : 32'h0;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a 7 ns async memory model.
// Per-cycle checker runs alongside the directed steps.
`timescale 1ns/1ps
module tb_mem_copy_dma;

  localparam int RW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy, done, mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  logic [31:0] mem [0:255];

  int          n_chk = 0;
  int          n_fail = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          done_cnt = 0;
  logic        rd_prev = 1'b0;
  logic [31:0] last_rd = '0;
  logic [31:0] rd_q [$];

  always #1.25 clk = ~clk;

  assign #7 mem_read_data = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  mem_copy_dma #(
    .READ_WAIT(RW),
    .CNT_W    (11)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [10:0] n, input bit restart,
                          output int cyc);
    int w0, r0, d0;
    bit busy_low;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    word_count = n;
    start = 1'b1;
    w0 = wr_cyc;
    r0 = rd_cyc;
    d0 = done_cnt;
    busy_low = 1'b0;
    @(posedge clk);
    #0.5;
    start = 1'b0;
    src_addr = 32'hDEAD_BEE0;
    dst_addr = 32'h0000_0040;
    word_count = 11'd7;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (!busy) busy_low = 1'b1;
      start = restart && (cyc == 3);
      @(posedge clk);
      #0.5;
      cyc++;
    end
    start = 1'b0;
    chk("busy_during_copy", 64'(busy_low), 64'd0);
    chk("done_latency", 64'(cyc), 64'(int'(n) * (RW + 1) + 1));
    chk("busy_at_done", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("read_cycles", 64'(rd_cyc - r0), 64'(int'(n) * RW));
    chk("write_cycles", 64'(wr_cyc - w0), 64'(int'(n)));
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc, q0, w, k, d0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    fork
      forever begin
        @(negedge clk);
        if (mem_read && !rd_prev) rd_q.push_back(mem_addr);
        rd_prev = mem_read;
        if (mem_read) rd_cyc++;
        if (mem_write) wr_cyc++;
        if (done) done_cnt++;
        chk("strobe_exclusive", 64'(mem_read && mem_write), 64'd0);
        if (mem_read) last_rd = mem_addr;
        if (mem_write)
          chk("write_data", 64'(mem_write_data), 64'(mem[last_rd[9:2]]));
        if (!mem_read && !mem_write)
          chk("idle_bus", {mem_addr, mem_write_data}, 64'd0);
      end
      forever begin
        @(posedge clk);
        if (mem_write) mem[mem_addr[9:2]] = mem_write_data;
      end
    join_none

    #0.3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd", 64'(mem_read), 64'd0);
    chk("rst_wr", 64'(mem_write), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_write_data), 64'd0);

    mem[8'h20] = 32'h11;
    mem[8'h21] = 32'h22;
    mem[8'h22] = 32'h33;
    mem[8'h23] = 32'h44;
    #3 reset = 1'b1;

    run_copy(32'h80, 32'h100, 11'd4, 1'b0, cyc);
    chk("cp4_w0", 64'(mem[8'h40]), 64'h11);
    chk("cp4_w1", 64'(mem[8'h41]), 64'h22);
    chk("cp4_w2", 64'(mem[8'h42]), 64'h33);
    chk("cp4_w3", 64'(mem[8'h43]), 64'h44);

    for (int i = 0; i < 4; i++) mem[8'h40 + i] = 32'h0;
    run_copy(32'h80, 32'h100, 11'd4, 1'b1, cyc);
    chk("restart_w0", 64'(mem[8'h40]), 64'h11);
    chk("restart_w3", 64'(mem[8'h43]), 64'h44);

    run_copy(32'h500, 32'h600, 11'd0, 1'b0, cyc);

    mem[8'hFF] = 32'hAAAA_0001;
    mem[8'h00] = 32'hBBBB_0002;
    q0 = rd_q.size();
    run_copy(32'hFFFF_FFFC, 32'h200, 11'd2, 1'b0, cyc);
    chk("wrap_nreads", 64'(rd_q.size() - q0), 64'd2);
    chk("wrap_rd0", 64'(rd_q[q0]), 64'hFFFF_FFFC);
    chk("wrap_rd1", 64'(rd_q[q0 + 1]), 64'h0);
    chk("wrap_w0", 64'(mem[8'h80]), 64'hAAAA_0001);
    chk("wrap_w1", 64'(mem[8'h81]), 64'hBBBB_0002);

    q0 = rd_q.size();
    run_copy(32'h83, 32'h303, 11'd1, 1'b0, cyc);
    chk("align_rd", 64'(rd_q[q0]), 64'h80);
    chk("align_w", 64'(mem[8'hC0]), 64'h11);

    mem[8'h24] = 32'h55;
    mem[8'h25] = 32'h66;
    mem[8'h26] = 32'h77;
    mem[8'h27] = 32'h88;
    d0 = done_cnt;
    @(negedge clk);
    src_addr = 32'h80;
    dst_addr = 32'h180;
    word_count = 11'd8;
    start = 1'b1;
    @(posedge clk);
    #0.5;
    start = 1'b0;
    w = 0;
    k = 0;
    while (w < 2 && k < 100) begin
      @(negedge clk);
      #0.1;
      if (mem_write) w++;
      k++;
    end
    chk("abort_reached_wr2", 64'(w), 64'd2);
    reset = 1'b0;
    #0.1;
    chk("abort_rd", 64'(mem_read), 64'd0);
    chk("abort_wr", 64'(mem_write), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_addr", 64'(mem_addr), 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_w0", 64'(mem[8'h60]), 64'h11);
    chk("abort_w1", 64'(mem[8'h61]), 64'h0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    @(negedge clk);
    src_addr = 32'h84;
    dst_addr = 32'h380;
    word_count = 11'd1;
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #0.5;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 50) begin
      @(posedge clk);
      #0.5;
      cyc++;
    end
    chk("post_rst_latency", 64'(cyc), 64'(RW + 2));
    repeat (2) @(negedge clk);
    chk("post_rst_w", 64'(mem[8'hE0]), 64'h22);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
